// File: rtl/latch_write_sched_pkg.sv
// Shared types for the latch write scheduler:
// sequencer states and requester identifiers.
package latch_write_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    PULSE = 2'd2,
    HOLD  = 2'd3
  } state_t;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } who_t;

endpackage

// File: rtl/latch_write_sched_if.sv
// Requester and latch-bank signals of the scheduler,
// slave = scheduler side, master = requesters/bank side.
interface latch_write_sched_if #(
  parameter int NREGS = 4,
  parameter int WIDTH = 8
);
  localparam int AW = $clog2(NREGS);

  logic             req_a;
  logic [AW-1:0]    addr_a;
  logic [WIDTH-1:0] data_a;
  logic             done_a;
  logic             req_b;
  logic [AW-1:0]    addr_b;
  logic [WIDTH-1:0] data_b;
  logic             done_b;
  logic [WIDTH-1:0] latch_d;
  logic [NREGS-1:0] latch_en;
  logic             busy;

  modport slave (
    input  req_a, addr_a, data_a,
    input  req_b, addr_b, data_b,
    output done_a, done_b,
    output latch_d, latch_en, busy
  );

  modport master (
    output req_a, addr_a, data_a,
    output req_b, addr_b, data_b,
    input  done_a, done_b,
    input  latch_d, latch_en, busy
  );
endinterface

// File: rtl/latch_write_sched_rr_arb2.sv
// Two-way round-robin arbiter; rr_last remembers
// the last winner so a tie goes to the other side.
module rr_arb2
  import latch_write_sched_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_a,
  input  logic req_b,
  input  logic take,
  output logic gnt_a,
  output logic gnt_b
);
  who_t rr_last;

  assign gnt_a = req_a & (~req_b | (rr_last == REQ_B));
  assign gnt_b = req_b & (~req_a | (rr_last == REQ_A));

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_last <= REQ_B;
    end else if (take & (gnt_a | gnt_b)) begin
      rr_last <= gnt_a ? REQ_A : REQ_B;
    end
  end
endmodule

// File: rtl/latch_write_sched.sv
// Write sequencer for a pulse-enabled latch bank:
// setup, single enable pulse, hold, then done.
module latch_write_sched
  import latch_write_sched_pkg::*;
#(
  parameter int NREGS     = 4,
  parameter int WIDTH     = 8,
  parameter int SETUP_CYC = 1,
  parameter int HOLD_CYC  = 1
) (
  input logic clk,
  input logic rst,
  latch_write_sched_if.slave bus
);
  localparam int AW = $clog2(NREGS);
  localparam int MC = (SETUP_CYC > HOLD_CYC) ?
                      SETUP_CYC : HOLD_CYC;
  localparam int CW = $clog2(MC + 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [AW-1:0]    addr_q;
  who_t             who_q;
  logic [WIDTH-1:0] d_q;
  logic [NREGS-1:0] en_q;
  logic             done_a_q;
  logic             done_b_q;
  logic             busy_q;
  logic             take;
  logic             gnt_a;
  logic             gnt_b;

  assign take = (state == IDLE);

  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .req_a (bus.req_a),
    .req_b (bus.req_b),
    .take  (take),
    .gnt_a (gnt_a),
    .gnt_b (gnt_b)
  );

  // done is registered, so it is raised on the edge
  // that enters the final hold cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      addr_q   <= '0;
      who_q    <= REQ_A;
      d_q      <= '0;
      en_q     <= '0;
      done_a_q <= 1'b0;
      done_b_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      en_q     <= '0;
      done_a_q <= 1'b0;
      done_b_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (gnt_a | gnt_b) begin
            state  <= SETUP;
            cnt    <= CW'(SETUP_CYC - 1);
            busy_q <= 1'b1;
            who_q  <= gnt_a ? REQ_A : REQ_B;
            addr_q <= gnt_a ? bus.addr_a : bus.addr_b;
            d_q    <= gnt_a ? bus.data_a : bus.data_b;
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            state <= PULSE;
            en_q  <= NREGS'(1) << addr_q;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        PULSE: begin
          state <= HOLD;
          cnt   <= CW'(HOLD_CYC - 1);
          if (HOLD_CYC == 1) begin
            done_a_q <= (who_q == REQ_A);
            done_b_q <= (who_q == REQ_B);
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
              done_a_q <= (who_q == REQ_A);
              done_b_q <= (who_q == REQ_B);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.latch_d  = d_q;
  assign bus.latch_en = en_q;
  assign bus.done_a   = done_a_q;
  assign bus.done_b   = done_b_q;
  assign bus.busy     = busy_q;
endmodule

// File: tb/tb_latch_write_sched.sv
// Bench for latch_write_sched: transaction-timeline
// reference model, directed cases, random traffic.
module tb_latch_write_sched;
  localparam int N = 4;
  localparam int W = 8;
  localparam int S = 1;
  localparam int H = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  latch_write_sched_if #(.NREGS(N), .WIDTH(W)) b1 ();
  latch_write_sched_if #(.NREGS(N), .WIDTH(W)) b2 ();

  latch_write_sched #(
    .NREGS(N), .WIDTH(W), .SETUP_CYC(S), .HOLD_CYC(H)
  ) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));

  latch_write_sched #(
    .NREGS(N), .WIDTH(W), .SETUP_CYC(3), .HOLD_CYC(2)
  ) dut2 (.clk(clk), .rst(rst), .bus(b2.slave));

  int errs = 0;
  int checks = 0;
  int n = 0;
  int t0 = 0;
  int na = 0;
  int nb = 0;
  int iss = 0;
  bit act = 1'b0;
  bit w_who = 1'b0;
  bit rr_last = 1'b1;
  bit hd_a = 1'b0;
  bit hd_b = 1'b0;
  bit drop_a = 1'b0;
  bit drop_b = 1'b0;
  logic [1:0] w_addr = '0;
  logic [7:0] w_data = '0;
  logic [7:0] last_d = '0;
  logic [3:0] prev_en = '0;
  logic [7:0] mem_m [4];
  logic [7:0] mem_d [4];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // One clock edge: advance the timeline model, then
  // compare dut1 against it a little after the edge.
  task automatic cyc();
    int k;
    logic [3:0] e_en;
    bit e_da;
    bit e_db;
    @(posedge clk);
    n++;
    drop_a = hd_a;
    drop_b = hd_b;
    if (rst) begin
      act = 0; last_d = '0; rr_last = 1;
      hd_a = 0; hd_b = 0;
    end else if (act && (n - t0 == S + H + 1)) begin
      act = 0;
    end else if (!act && (b1.req_a || b1.req_b)) begin
      w_who = b1.req_b && (!b1.req_a || rr_last == 1'b0);
      rr_last = w_who;
      w_addr = w_who ? b1.addr_b : b1.addr_a;
      w_data = w_who ? b1.data_b : b1.data_a;
      last_d = w_data;
      t0 = n;
      act = 1;
    end
    #1;
    k = n - t0 + 1;
    e_en = (act && k == S + 1) ? (4'd1 << w_addr) : 4'd0;
    e_da = act && (k == S + H + 1) && !w_who;
    e_db = act && (k == S + H + 1) && w_who;
    if (e_en != 4'd0) mem_m[w_addr] = w_data;
    hd_a = e_da;
    hd_b = e_db;
    chk("busy", b1.busy, act);
    chk("latch_en", b1.latch_en, e_en);
    chk("latch_d", b1.latch_d, last_d);
    chk("done_a", b1.done_a, e_da);
    chk("done_b", b1.done_b, e_db);
    chk("en_onehot0", $countones(b1.latch_en) <= 1, 1);
    chk("en_gap", |(b1.latch_en & prev_en), 0);
    prev_en = b1.latch_en;
    for (int i = 0; i < N; i++)
      if (b1.latch_en[i]) mem_d[i] = b1.latch_d;
    if (b1.done_a) na++;
    if (b1.done_b) nb++;
    if (drop_a) b1.req_a = 1'b0;
    if (drop_b) b1.req_b = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      mem_m[i] = '0;
      mem_d[i] = '0;
    end
    b1.req_a = 0; b1.addr_a = '0; b1.data_a = '0;
    b1.req_b = 0; b1.addr_b = '0; b1.data_b = '0;
    b2.req_a = 0; b2.addr_a = '0; b2.data_a = '0;
    b2.req_b = 0; b2.addr_b = '0; b2.data_b = '0;
    repeat (2) cyc();
    chk("rst_busy2", b2.busy, 0);
    chk("rst_en2", b2.latch_en, 0);
    chk("rst_d2", b2.latch_d, 0);
    chk("rst_dn2", {b2.done_a, b2.done_b}, 0);
    rst = 0;

    // A alone: addr 2, 0xA5
    b1.req_a = 1; b1.addr_a = 2'd2; b1.data_a = 8'hA5;
    cyc();
    chk("t1_d", b1.latch_d, 8'hA5);
    chk("t1_busy1", b1.busy, 1);
    cyc();
    chk("t1_en", b1.latch_en, 4'b0100);
    cyc();
    chk("t1_done", b1.done_a, 1);
    cyc();
    chk("t1_idle", b1.busy, 0);

    rst = 1; cyc(); rst = 0;

    // simultaneous A and B
    b1.req_a = 1; b1.addr_a = 2'd1; b1.data_a = 8'h11;
    b1.req_b = 1; b1.addr_b = 2'd3; b1.data_b = 8'h33;
    for (int c = 1; c <= 8; c++) begin
      cyc();
      if (c == 2) chk("t2_en_a", b1.latch_en, 4'b0010);
      if (c == 6) chk("t2_en_b", b1.latch_en, 4'b1000);
      if (c == 7) chk("t2_done_b", b1.done_b, 1);
    end

    // sustained contention: ten writes alternate
    na = 0; nb = 0; iss = 2;
    b1.req_a = 1; b1.addr_a = 2'd0; b1.data_a = 8'($urandom);
    b1.req_b = 1; b1.addr_b = 2'd2; b1.data_b = 8'($urandom);
    repeat (40) begin
      cyc();
      if (drop_a && iss < 10) begin
        b1.req_a = 1; b1.data_a = 8'($urandom); iss++;
      end
      if (drop_b && iss < 10) begin
        b1.req_b = 1; b1.data_b = 8'($urandom); iss++;
      end
    end
    chk("t3_na", na, 5);
    chk("t3_nb", nb, 5);

    // long setup/hold instance, B writes addr 0
    b2.req_b = 1; b2.addr_b = 2'd0; b2.data_b = 8'h7E;
    for (int k = 1; k <= 7; k++) begin
      cyc();
      chk("t4_en", b2.latch_en, (k == 4) ? 4'b0001 : 4'b0000);
      chk("t4_done_b", b2.done_b, k == 6);
      chk("t4_done_a", b2.done_a, 0);
      chk("t4_busy", b2.busy, k <= 6);
      if (k <= 6) chk("t4_d", b2.latch_d, 8'h7E);
      if (k == 7) b2.req_b = 0;
    end

    // reset on the edge that would start the pulse
    b1.req_a = 1; b1.addr_a = 2'd3; b1.data_a = 8'h5C;
    cyc();
    chk("t5_setup", b1.busy, 1);
    rst = 1; b1.req_a = 0;
    cyc();
    rst = 0;
    chk("t5_en", b1.latch_en, 0);
    chk("t5_d", b1.latch_d, 0);
    chk("t5_busy", b1.busy, 0);
    chk("t5_done", {b1.done_a, b1.done_b}, 0);
    repeat (4) begin
      cyc();
      chk("t5_en_quiet", b1.latch_en, 0);
      chk("t5_dn_quiet", b1.done_a, 0);
    end

    // random traffic honouring the requester contract
    repeat (1000) begin
      cyc();
      if (!b1.req_a && $urandom_range(0, 2) == 0) begin
        b1.req_a = 1;
        b1.addr_a = 2'($urandom_range(0, 3));
        b1.data_a = 8'($urandom);
      end
      if (!b1.req_b && $urandom_range(0, 2) == 0) begin
        b1.req_b = 1;
        b1.addr_b = 2'($urandom_range(0, 3));
        b1.data_b = 8'($urandom);
      end
    end
    repeat (10) cyc();
    chk("drained", {b1.req_a, b1.req_b, b1.busy}, 0);
    for (int i = 0; i < N; i++)
      chk($sformatf("mem%0d", i), mem_d[i], mem_m[i]);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
